// File: rtl/axi_src_isolate.sv
// axi_src_isolate: source-domain AXI isolation stage in front of the CDC source half.
// Passes AW/W/AR and B/R through with zero latency. On isolate_i it stops accepting
// new AW/AR and waits until everything already forwarded has completed, then reports
// isolated_o.
// Optional build macro: AXI_SRC_ISOLATE_STATUS_EN adds the pending_wr_o/pending_rd_o ports.

package axi_src_isolate_pkg;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } axi_ax_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } axi_w_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } axi_b_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } axi_r_t;

    typedef struct packed {
        axi_ax_t aw;
        logic    aw_valid;
        axi_w_t  w;
        logic    w_valid;
        logic    b_ready;
        axi_ax_t ar;
        logic    ar_valid;
        logic    r_ready;
    } axi_req_t;

    typedef struct packed {
        logic   aw_ready;
        logic   w_ready;
        axi_b_t b;
        logic   b_valid;
        logic   ar_ready;
        axi_r_t r;
        logic   r_valid;
    } axi_resp_t;

endpackage

module axi_src_isolate #(
    parameter int unsigned MaxTxn     = 8,
    parameter type         axi_req_t  = axi_src_isolate_pkg::axi_req_t,
    parameter type         axi_resp_t = axi_src_isolate_pkg::axi_resp_t
) (
    input  logic      src_clk_i,
    input  logic      src_rst_ni,
    input  axi_req_t  slv_req_i,
    output axi_resp_t slv_resp_o,
    output axi_req_t  mst_req_o,
    input  axi_resp_t mst_resp_i,
    input  logic      isolate_i,
    output logic      isolated_o
`ifdef AXI_SRC_ISOLATE_STATUS_EN
    ,
    output logic [$clog2(MaxTxn+1)-1:0] pending_wr_o,
    output logic [$clog2(MaxTxn+1)-1:0] pending_rd_o
`endif
);

    localparam int unsigned     CntW   = $clog2(MaxTxn + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(MaxTxn);

    typedef enum logic [1:0] {
        ST_NORMAL,
        ST_DRAIN,
        ST_ISOLATED
    } state_e;

    state_e          r_state;
    state_e          w_state_nxt;

    logic [CntW-1:0] r_wr_cnt;
    logic [CntW-1:0] r_w_cnt;
    logic [CntW-1:0] r_rd_cnt;
    logic            r_aw_hold;
    logic            r_w_hold;
    logic            r_ar_hold;

    logic            w_aw_allow;
    logic            w_w_allow;
    logic            w_ar_allow;
    logic            w_aw_valid;
    logic            w_w_valid;
    logic            w_ar_valid;
    logic            w_aw_hs;
    logic            w_w_hs;
    logic            w_w_last_hs;
    logic            w_ar_hs;
    logic            w_b_hs;
    logic            w_r_last_hs;
    logic            w_idle;

    // Allows use registered counts only, so a same-cycle B/R never reopens AW/AR.
    // A held channel stays open so a forwarded valid is never retracted.
    assign w_aw_allow = ((r_state == ST_NORMAL) && (r_wr_cnt < CntMax)) || r_aw_hold;
    assign w_ar_allow = ((r_state == ST_NORMAL) && (r_rd_cnt < CntMax)) || r_ar_hold;
    assign w_aw_valid = slv_req_i.aw_valid & w_aw_allow;
    assign w_ar_valid = slv_req_i.ar_valid & w_ar_allow;
    assign w_aw_hs    = w_aw_valid & mst_resp_i.aw_ready;
    assign w_ar_hs    = w_ar_valid & mst_resp_i.ar_ready;

    // W needs a matching AW, either already counted or handshaking right now.
    assign w_w_allow   = (r_w_cnt != '0) || w_aw_hs || r_w_hold;
    assign w_w_valid   = slv_req_i.w_valid & w_w_allow;
    assign w_w_hs      = w_w_valid & mst_resp_i.w_ready;
    assign w_w_last_hs = w_w_hs & slv_req_i.w.last;

    assign w_b_hs      = mst_resp_i.b_valid & slv_req_i.b_ready;
    assign w_r_last_hs = mst_resp_i.r_valid & slv_req_i.r_ready & mst_resp_i.r.last;

    assign w_idle = (r_wr_cnt == '0) && (r_w_cnt == '0) && (r_rd_cnt == '0) &&
                    !r_aw_hold && !r_w_hold && !r_ar_hold;

    assign isolated_o = (r_state == ST_ISOLATED);

`ifdef AXI_SRC_ISOLATE_STATUS_EN
    assign pending_wr_o = r_wr_cnt;
    assign pending_rd_o = r_rd_cnt;
`endif

    // Payload pass-through with valid/ready gating on the request channels
    always_comb begin
        mst_req_o          = slv_req_i;
        mst_req_o.aw_valid = w_aw_valid;
        mst_req_o.w_valid  = w_w_valid;
        mst_req_o.ar_valid = w_ar_valid;

        slv_resp_o          = mst_resp_i;
        slv_resp_o.aw_ready = mst_resp_i.aw_ready & w_aw_allow;
        slv_resp_o.w_ready  = mst_resp_i.w_ready & w_w_allow;
        slv_resp_o.ar_ready = mst_resp_i.ar_ready & w_ar_allow;
    end

    function automatic logic [CntW-1:0] cnt_next(input logic [CntW-1:0] cnt,
                                                 input logic            inc,
                                                 input logic            dec);
        logic [CntW-1:0] res;
        res = cnt;
        if (inc && !dec) begin
            res = cnt + CntW'(1);
        end else if (dec && !inc && (cnt != '0)) begin
            res = cnt - CntW'(1);
        end
        return res;
    endfunction

    // Outstanding-transaction counters and downstream valid hold flags
    always_ff @(posedge src_clk_i or negedge src_rst_ni) begin
        if (!src_rst_ni) begin
            r_wr_cnt  <= '0;
            r_w_cnt   <= '0;
            r_rd_cnt  <= '0;
            r_aw_hold <= 1'b0;
            r_w_hold  <= 1'b0;
            r_ar_hold <= 1'b0;
        end else begin
            r_wr_cnt  <= cnt_next(r_wr_cnt, w_aw_hs, w_b_hs);
            r_w_cnt   <= cnt_next(r_w_cnt, w_aw_hs, w_w_last_hs);
            r_rd_cnt  <= cnt_next(r_rd_cnt, w_ar_hs, w_r_last_hs);
            r_aw_hold <= w_aw_valid & ~mst_resp_i.aw_ready;
            r_w_hold  <= w_w_valid & ~mst_resp_i.w_ready;
            r_ar_hold <= w_ar_valid & ~mst_resp_i.ar_ready;
        end
    end

    // State register
    always_ff @(posedge src_clk_i or negedge src_rst_ni) begin
        if (!src_rst_ni) begin
            r_state <= ST_NORMAL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: a dropped isolate request wins over completing the drain
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_NORMAL: begin
                if (isolate_i) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!isolate_i) w_state_nxt = ST_NORMAL;
                else if (w_idle) w_state_nxt = ST_ISOLATED;
            end
            ST_ISOLATED: begin
                if (!isolate_i) w_state_nxt = ST_NORMAL;
            end
            default: w_state_nxt = ST_NORMAL;
        endcase
    end

`ifndef SYNTHESIS
    // A response with nothing outstanding means the downstream side broke protocol
    a_wr_underflow: assert property (@(posedge src_clk_i) disable iff (!src_rst_ni)
        !(w_b_hs && !w_aw_hs && (r_wr_cnt == '0)));
    a_w_underflow: assert property (@(posedge src_clk_i) disable iff (!src_rst_ni)
        !(w_w_last_hs && !w_aw_hs && (r_w_cnt == '0)));
    a_rd_underflow: assert property (@(posedge src_clk_i) disable iff (!src_rst_ni)
        !(w_r_last_hs && !w_ar_hs && (r_rd_cnt == '0)));
`endif

endmodule
